// File: rtl/sem_peticion_pkg.sv
// Shared constants and FSM encoding for the pedestrian request stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sem_peticion_pkg;

    localparam int unsigned CUENTA_W       = 6;
    localparam int unsigned TICK_DIV_DEF   = 50_000_000;
    localparam int unsigned DEB_CYCLES_DEF = 1_000_000;
    localparam int unsigned JUMP_TO_DEF    = 25;
    localparam int unsigned AMBER_AT_DEF   = 30;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,  // no request outstanding
        ST_PEND = 2'd1,  // request accepted, waiting for the next tick to load
        ST_WAIT = 2'd2   // request served (or green already short), wait for amber
    } sem_state_e;

endpackage

// File: rtl/sem_antirrebote.sv
// Button filter: 2-FF synchronizer, run-length debouncer, falling-edge detector.
// Latency: PRESS pulses 2 + DEB_CYCLES + 1 cycles after a clean press reaches KEYn.
// Backpressure: none; one PRESS per accepted 1->0 transition of the filtered level.
// Ports: CLK/RSTn clock and async active-low reset, KEYn raw button (active low),
//        PRESS one-cycle pulse per debounced press.
module sem_antirrebote
    import sem_peticion_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic KEYn,
    output logic PRESS
);

    localparam int unsigned   DW       = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          filt_q,  filt_d;
    logic [DW-1:0] cnt_q,   cnt_d;
    logic          press_q, press_d;

    // cnt_q holds how many consecutive samples have disagreed with the
    // filtered level; any agreeing sample restarts the run.
    always_comb begin
        sync1_d = KEYn;
        sync2_d = sync1_q;
        filt_d  = filt_q;
        cnt_d   = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == DEB_LAST) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + DW'(1);
            end
        end
        press_d = filt_q & ~filt_d;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign PRESS = press_q;

endmodule

// File: rtl/sem_peticion.sv
// Traffic-light upstream control: 1 Hz tick prescaler plus pedestrian request FSM.
// Latency: debounced press to SEM_LOADn low within TICK_DIV+1 cycles; all outputs registered.
// Backpressure: none; presses arriving outside IDLE are dropped.
// Ports: CLK/RSTn clock and async active-low reset, KEYn raw button, CUENTA current
//        second count; CLK_ENA tick, SEM_LOADn/SEM_P counter load, REQ_LED request lamp.
module sem_peticion
    import sem_peticion_pkg::*;
#(
    parameter int unsigned TICK_DIV   = TICK_DIV_DEF,
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int unsigned JUMP_TO    = JUMP_TO_DEF,
    parameter int unsigned AMBER_AT   = AMBER_AT_DEF
) (
    input  logic                CLK,
    input  logic                RSTn,
    input  logic                KEYn,
    input  logic [CUENTA_W-1:0] CUENTA,
    output logic                CLK_ENA,
    output logic                SEM_LOADn,
    output logic [CUENTA_W-1:0] SEM_P,
    output logic                REQ_LED
);

    localparam int unsigned         PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]       PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CUENTA_W-1:0] JUMP_V     = CUENTA_W'(JUMP_TO);
    localparam logic [CUENTA_W-1:0] AMBER_V    = CUENTA_W'(AMBER_AT);

    logic       press;
    logic       wrap;
    logic       before_jump;
    logic       in_amber_or_later;

    logic [PW-1:0] presc_q,     presc_d;
    logic          clk_ena_q,   clk_ena_d;
    logic          sem_loadn_q, sem_loadn_d;
    logic          req_led_q,   req_led_d;
    sem_state_e    state_q,     state_d;

    sem_antirrebote #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_antirrebote (
        .CLK   (CLK),
        .RSTn  (RSTn),
        .KEYn  (KEYn),
        .PRESS (press)
    );

    assign wrap              = (presc_q == PRESC_LAST);
    assign before_jump       = (CUENTA < JUMP_V);
    assign in_amber_or_later = (CUENTA >= AMBER_V);

    // Prescaler: CLK_ENA is registered off the terminal count, so it rises on
    // the same edge the count returns to zero.
    always_comb begin
        presc_d   = wrap ? '0 : presc_q + PW'(1);
        clk_ena_d = wrap;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (press && !in_amber_or_later) begin
                    state_d = before_jump ? ST_PEND : ST_WAIT;
                end
            end
            ST_PEND: begin
                if (wrap) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (in_amber_or_later) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic. The load is only issued on the wrap edge, so the strobe
    // is registered alongside CLK_ENA and can never appear without it. If
    // the count already passed JUMP_TO the green is short enough: no load.
    always_comb begin
        sem_loadn_d = !((state_q == ST_PEND) && wrap && before_jump);
        req_led_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            presc_q     <= '0;
            clk_ena_q   <= 1'b0;
            sem_loadn_q <= 1'b1;
            req_led_q   <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            clk_ena_q   <= clk_ena_d;
            sem_loadn_q <= sem_loadn_d;
            req_led_q   <= req_led_d;
        end
    end

    assign CLK_ENA   = clk_ena_q;
    assign SEM_LOADn = sem_loadn_q;
    assign REQ_LED   = req_led_q;
    assign SEM_P     = JUMP_V;

endmodule

// File: tb/tb_sem_peticion.sv
// Bench for sem_peticion: directed scenarios plus a randomized run with a
// traffic-light counter environment, all checked every cycle against a model.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_sem_peticion;

    localparam int TICK  = 4;
    localparam int DEB   = 3;
    localparam int JUMP  = 25;
    localparam int AMBER = 30;
    localparam int LAST  = 55;

    localparam int M_IDLE = 0;
    localparam int M_PEND = 1;
    localparam int M_WAIT = 2;

    logic       CLK = 1'b0;
    logic       RSTn;
    logic       KEYn;
    logic [5:0] CUENTA;
    logic       CLK_ENA;
    logic       SEM_LOADn;
    logic [5:0] SEM_P;
    logic       REQ_LED;

    int n_tests  = 0;
    int n_fail   = 0;
    int load_cnt = 0;

    sem_peticion #(
        .TICK_DIV   (TICK),
        .DEB_CYCLES (DEB),
        .JUMP_TO    (JUMP),
        .AMBER_AT   (AMBER)
    ) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .KEYn      (KEYn),
        .CUENTA    (CUENTA),
        .CLK_ENA   (CLK_ENA),
        .SEM_LOADn (SEM_LOADn),
        .SEM_P     (SEM_P),
        .REQ_LED   (REQ_LED)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Ticks: one every TICK edges counted from reset release.
    // Button: seen two edges late; the level flips once DEB samples in a row disagree.
    int unsigned m_edges    = 0;
    bit          m_keys[$]  = '{1'b1, 1'b1};
    bit          m_filt     = 1'b1;
    int          m_diff_run = 0;
    bit          m_press    = 1'b0;
    int          m_phase    = M_IDLE;
    int          m_loads    = 0;
    bit          e_ena      = 1'b0;
    bit          e_loadn    = 1'b1;
    bit          e_led      = 1'b0;

    always @(posedge CLK) begin
        bit sync_now;
        bit fell;
        bit tick_now;
        if (!RSTn) begin
            m_edges    = 0;
            m_keys     = '{1'b1, 1'b1};
            m_filt     = 1'b1;
            m_diff_run = 0;
            m_press    = 1'b0;
            m_phase    = M_IDLE;
            e_ena      = 1'b0;
            e_loadn    = 1'b1;
            e_led      = 1'b0;
        end else begin
            m_keys.push_back(KEYn);
            sync_now = m_keys.pop_front();
            fell = 1'b0;
            if (sync_now != m_filt) begin
                m_diff_run++;
                if (m_diff_run == DEB) begin
                    fell       = m_filt && !sync_now;
                    m_filt     = sync_now;
                    m_diff_run = 0;
                end
            end else begin
                m_diff_run = 0;
            end

            m_edges++;
            tick_now = ((m_edges % TICK) == 0);

            e_loadn = 1'b1;
            case (m_phase)
                M_IDLE: if (m_press) begin
                    if (int'(CUENTA) < JUMP)       m_phase = M_PEND;
                    else if (int'(CUENTA) < AMBER) m_phase = M_WAIT;
                end
                M_PEND: if (tick_now) begin
                    if (int'(CUENTA) < JUMP) begin
                        e_loadn = 1'b0;
                        m_loads++;
                    end
                    m_phase = M_WAIT;
                end
                default: if (int'(CUENTA) >= AMBER) m_phase = M_IDLE;
            endcase
            e_ena   = tick_now;
            e_led   = (m_phase != M_IDLE);
            m_press = fell;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge CLK) begin
        #1;
        check("clk_ena",   CLK_ENA,   e_ena);
        check("sem_loadn", SEM_LOADn, e_loadn);
        check("req_led",   REQ_LED,   e_led);
        check("sem_p",     SEM_P,     JUMP);
        if (SEM_LOADn == 1'b0) begin
            load_cnt++;
            check("load_outside_tick", CLK_ENA, 1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic press(input int len);
        KEYn = 1'b0;
        repeat (len) @(negedge CLK);
        KEYn = 1'b1;
    endtask

    initial begin
        int  n;
        bit  seen;
        int  hold;

        // 1: reset with the button held, then tick period after release
        RSTn   = 1'b0;
        KEYn   = 1'b0;
        CUENTA = 6'd10;
        tick(3);
        check("rst_clk_ena",   CLK_ENA,   0);
        check("rst_sem_loadn", SEM_LOADn, 1);
        check("rst_req_led",   REQ_LED,   0);
        check("rst_sem_p",     SEM_P,     25);
        RSTn = 1'b1;
        KEYn = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!CLK_ENA && n < 20);
        check("first_tick_delay", n, 4);
        tick(3);
        check("tick_gap_low", CLK_ENA, 0);
        tick(1);
        check("tick_period", CLK_ENA, 1);

        // 2: bounce shorter than the debounce window
        for (int i = 0; i < 6; i++) begin
            KEYn = 1'b0;
            tick(2);
            KEYn = 1'b1;
            tick(2);
        end
        tick(6);
        check("bounce_no_led", REQ_LED, 0);
        check("bounce_no_load", load_cnt, 0);

        // 3: valid press early in green -> one load, lamp until amber
        load_cnt = 0;
        m_loads  = 0;
        press(10);
        tick(2);
        check("s3_one_load", load_cnt, 1);
        check("s3_model_loads", m_loads, 1);
        check("s3_led_on", REQ_LED, 1);
        CUENTA = 6'd25;
        tick(3);
        check("s3_led_hold", REQ_LED, 1);
        CUENTA = 6'd30;
        tick(1);
        check("s3_led_off", REQ_LED, 0);
        check("s3_still_one_load", load_cnt, 1);

        // 4: press late in green -> no load; press in amber/ped -> ignored
        load_cnt = 0;
        CUENTA   = 6'd27;
        press(10);
        tick(4);
        check("s4_led_on", REQ_LED, 1);
        CUENTA = 6'd30;
        tick(2);
        check("s4_led_off", REQ_LED, 0);
        check("s4_no_load", load_cnt, 0);
        CUENTA = 6'd40;
        press(10);
        tick(4);
        check("s4_amber_ignored", REQ_LED, 0);
        check("s4_amber_no_load", load_cnt, 0);

        // 5: second press and long hold both give a single load
        CUENTA   = 6'd10;
        load_cnt = 0;
        press(5);
        tick(6);
        press(5);
        tick(10);
        check("s5_double_one_load", load_cnt, 1);
        check("s5_led_on", REQ_LED, 1);
        CUENTA = 6'd30;
        tick(2);
        CUENTA   = 6'd10;
        load_cnt = 0;
        press(100);
        tick(5);
        check("s5_hold_one_load", load_cnt, 1);
        CUENTA = 6'd30;
        tick(2);
        check("s5_led_off", REQ_LED, 0);

        // 6: reset while a request is pending drops it
        CUENTA   = 6'd10;
        load_cnt = 0;
        press(5);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge CLK);
            seen = REQ_LED;
        end
        check("s6_pend_seen", seen, 1);
        RSTn = 1'b0;
        tick(1);
        check("s6_rst_led", REQ_LED, 0);
        check("s6_rst_loadn", SEM_LOADn, 1);
        tick(2);
        RSTn = 1'b1;
        tick(8);
        check("s6_after_rst_led", REQ_LED, 0);
        check("s6_no_load", load_cnt, 0);
        press(10);
        tick(2);
        check("s6_new_press_load", load_cnt, 1);
        check("s6_new_press_led", REQ_LED, 1);

        // Randomized run: counter follows ticks and loads, random button levels
        CUENTA = 6'd0;
        KEYn   = 1'b1;
        hold   = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge CLK);
            if (!RSTn) begin
                RSTn = 1'b1;
            end else if ($urandom_range(0, 1499) == 0) begin
                RSTn = 1'b0;
            end
            if (CLK_ENA) begin
                if (!SEM_LOADn) CUENTA = 6'(JUMP);
                else            CUENTA = (int'(CUENTA) == LAST) ? 6'd0 : CUENTA + 6'd1;
            end
            if (hold > 0) begin
                hold--;
            end else begin
                KEYn = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 12);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
